// File: rtl/ped_request_unit.sv
// Pedestrian request front end: per-direction button synchroniser, debouncer,
// press-edge detector and request FSM feeding the traffic light controller.
// The NS and EW directions are two identical, independent instances of
// ped_request_dir.

module ped_request_dir #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_i,
  input  logic             walk_i,
  output logic             ped_o,
  output logic             wait_o,
  output logic [CNT_W-1:0] srv_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SERVING = 2'd2
  } state_e;

  localparam logic [7:0] DB_N = 8'(DEBOUNCE_CYCLES);

  logic             s1_q, s2_q;
  logic             db_q, db_d;
  logic             db_dly_q;
  logic [7:0]       dc_q, dc_d;
  logic             press_q, press_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] srv_q, srv_d;

  // Two-flop synchroniser for the asynchronous button pin.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
    end
  end

  // Debounce: accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
  always_comb begin
    db_d = db_q;
    dc_d = dc_q;
    if (s2_q == db_q) begin
      dc_d = 8'd0;
    end else if ((dc_q + 8'd1) == DB_N) begin
      db_d = s2_q;
      dc_d = 8'd0;
    end else begin
      dc_d = dc_q + 8'd1;
    end
  end

  // Press event: one-cycle pulse on the edge after the debounced level rises.
  always_comb begin
    press_d = db_q & ~db_dly_q;
  end

  // Debounce state, delayed level for edge detection, and registered press pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db_q     <= 1'b0;
      dc_q     <= 8'd0;
      db_dly_q <= 1'b0;
      press_q  <= 1'b0;
    end else begin
      db_q     <= db_d;
      dc_q     <= dc_d;
      db_dly_q <= db_q;
      press_q  <= press_d;
    end
  end

  // Request FSM and serviced counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      srv_q   <= '0;
    end else begin
      state_q <= state_d;
      srv_q   <= srv_d;
    end
  end

  // Next state: latch a press unless the crossing is already open, count on acknowledge.
  always_comb begin
    state_d = state_q;
    srv_d   = srv_q;
    case (state_q)
      IDLE: begin
        if (press_q && !walk_i) begin
          state_d = PENDING;
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        if (walk_i) begin
          state_d = SERVING;
          srv_d   = srv_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_d = PENDING;
        end
      end
      SERVING: begin
        if (!walk_i) begin
          state_d = IDLE;
        end else begin
          state_d = SERVING;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decoded from the registered state only, so they never glitch.
  always_comb begin
    ped_o  = 1'b0;
    wait_o = 1'b0;
    case (state_q)
      PENDING: begin
        ped_o  = 1'b1;
        wait_o = 1'b1;
      end
      default: begin
        ped_o  = 1'b0;
        wait_o = 1'b0;
      end
    endcase
  end

  assign srv_o = srv_q;

endmodule

module ped_request_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_ns,
  input  logic             btn_ew,
  input  logic             ns_walk,
  input  logic             ew_walk,
  output logic             ped_ns,
  output logic             ped_ew,
  output logic             wait_ns,
  output logic             wait_ew,
  output logic [CNT_W-1:0] srv_ns,
  output logic [CNT_W-1:0] srv_ew
);

  ped_request_dir #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ns (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_ns),
    .walk_i (ns_walk),
    .ped_o  (ped_ns),
    .wait_o (wait_ns),
    .srv_o  (srv_ns)
  );

  ped_request_dir #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_ew (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_ew),
    .walk_i (ew_walk),
    .ped_o  (ped_ew),
    .wait_o (wait_ew),
    .srv_o  (srv_ew)
  );

endmodule

// File: tb/tb_ped_request_unit.sv
// Directed testbench for ped_request_unit with DEBOUNCE_CYCLES = 4, CNT_W = 8.

module tb_ped_request_unit;

  logic       clk;
  logic       reset;
  logic       btn_ns, btn_ew;
  logic       ns_walk, ew_walk;
  logic       ped_ns, ped_ew;
  logic       wait_ns, wait_ew;
  logic [7:0] srv_ns, srv_ew;

  int n_checks = 0;
  int n_errors = 0;

  ped_request_unit #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_ns  (btn_ns),
    .btn_ew  (btn_ew),
    .ns_walk (ns_walk),
    .ew_walk (ew_walk),
    .ped_ns  (ped_ns),
    .ped_ew  (ped_ew),
    .wait_ns (wait_ns),
    .wait_ew (wait_ew),
    .srv_ns  (srv_ns),
    .srv_ew  (srv_ew)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, returning 1 time unit after the last one.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Clean 10-cycle press followed by enough low cycles for the debouncer to settle low.
  task automatic do_press(input bit ew);
    if (ew) btn_ew = 1'b1; else btn_ns = 1'b1;
    tick(10);
    if (ew) btn_ew = 1'b0; else btn_ns = 1'b0;
    tick(8);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ped_ns"},  32'(ped_ns),  32'd0);
    check({tag, "_ped_ew"},  32'(ped_ew),  32'd0);
    check({tag, "_wait_ns"}, 32'(wait_ns), 32'd0);
    check({tag, "_wait_ew"}, 32'(wait_ew), 32'd0);
    check({tag, "_srv_ns"},  32'(srv_ns),  32'd0);
    check({tag, "_srv_ew"},  32'(srv_ew),  32'd0);
  endtask

  initial begin
    logic [8:0] pat;

    reset   = 1'b0;
    btn_ns  = 1'b0;
    btn_ew  = 1'b0;
    ns_walk = 1'b0;
    ew_walk = 1'b0;

    // Reset held with buttons toggling.
    for (int i = 0; i < 12; i++) begin
      btn_ns = ~btn_ns;
      btn_ew = (i % 3 == 0);
      tick(1);
    end
    check_all_zero("in_reset");
    btn_ns = 1'b0;
    btn_ew = 1'b0;
    reset  = 1'b1;
    tick(20);
    check_all_zero("idle_after_reset");

    // Clean NS press: request visible exactly 7 edges after E0.
    btn_ns = 1'b1;
    tick(7);
    check("ns_press_e6", 32'(ped_ns), 32'd0);
    tick(1);
    check("ns_press_e7_ped",  32'(ped_ns),  32'd1);
    check("ns_press_e7_wait", 32'(wait_ns), 32'd1);
    check("ns_press_ew_idle", 32'(ped_ew),  32'd0);
    tick(2);
    btn_ns = 1'b0;
    tick(3);
    check("ns_held_pending", 32'(ped_ns), 32'd1);

    // Walk pulse while EW idle, then a valid EW press during walk: both ignored.
    ew_walk = 1'b1;
    tick(5);
    check("ew_idle_walk_srv", 32'(srv_ew), 32'd0);
    check("ew_idle_walk_ped", 32'(ped_ew), 32'd0);
    do_press(1'b1);
    check("ew_press_in_walk_ped", 32'(ped_ew), 32'd0);
    check("ew_press_in_walk_srv", 32'(srv_ew), 32'd0);
    ew_walk = 1'b0;
    tick(3);
    check("ew_after_walk_ped", 32'(ped_ew), 32'd0);

    // Bounce pattern 1,0,1,1,0,1,1,1,0 then 6 stable high cycles.
    pat = 9'b011101101;
    for (int i = 0; i < 9; i++) begin
      btn_ew = pat[i];
      tick(1);
    end
    check("ew_bounce_ped", 32'(ped_ew), 32'd0);
    btn_ew = 1'b1;
    tick(6);
    btn_ew = 1'b0;
    tick(1);
    check("ew_stable_e6", 32'(ped_ew), 32'd0);
    tick(1);
    check("ew_stable_e7_ped",  32'(ped_ew),  32'd1);
    check("ew_stable_e7_wait", 32'(wait_ew), 32'd1);
    tick(8);

    // NS acknowledge with a press landing inside the walk phase.
    check("ns_pending_before_ack", 32'(ped_ns), 32'd1);
    btn_ns = 1'b1;
    tick(3);
    ns_walk = 1'b1;
    tick(1);
    check("ns_ack_ped",  32'(ped_ns),  32'd0);
    check("ns_ack_wait", 32'(wait_ns), 32'd0);
    check("ns_ack_srv",  32'(srv_ns),  32'd1);
    tick(4);
    btn_ns  = 1'b0;
    ns_walk = 1'b0;
    tick(11);
    check("ns_press_in_walk_ped", 32'(ped_ns), 32'd0);
    check("ns_press_in_walk_srv", 32'(srv_ns), 32'd1);

    // New NS press after walk ends.
    btn_ns = 1'b1;
    tick(7);
    check("ns_repress_e6", 32'(ped_ns), 32'd0);
    tick(1);
    check("ns_repress_e7", 32'(ped_ns), 32'd1);
    tick(2);
    btn_ns = 1'b0;
    tick(8);

    // Acknowledge the pending EW request.
    ew_walk = 1'b1;
    tick(1);
    check("ew_ack_ped", 32'(ped_ew), 32'd0);
    check("ew_ack_srv", 32'(srv_ew), 32'd1);
    ew_walk = 1'b0;
    tick(2);

    // Service NS until the counter wraps: 1 + 255 services = 256 -> 0.
    for (int i = 0; i < 255; i++) begin
      if (i == 254) check("ns_srv_255", 32'(srv_ns), 32'd255);
      ns_walk = 1'b1;
      tick(1);
      ns_walk = 1'b0;
      tick(1);
      do_press(1'b0);
    end
    check("ns_srv_wrap", 32'(srv_ns), 32'd0);
    check("ns_pending_after_wrap", 32'(ped_ns), 32'd1);

    // Pending EW then an asynchronous reset pulse between edges.
    do_press(1'b1);
    check("ew_pending_pre_reset", 32'(ped_ew), 32'd1);
    reset = 1'b0;
    #1;
    check("midreset_ped_ew",  32'(ped_ew),  32'd0);
    check("midreset_wait_ew", 32'(wait_ew), 32'd0);
    check("midreset_ped_ns",  32'(ped_ns),  32'd0);
    check("midreset_srv_ew",  32'(srv_ew),  32'd0);
    #2;
    reset = 1'b1;
    tick(3);
    check_all_zero("post_midreset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
